// File: rtl/reg_decoder_seq.sv
// reg_decoder_seq
//   One-hot decoder with a registered output, used to drive register-file
//   write enables. Besides single-cycle decodes it can sweep every line once,
//   in ascending order, so the register file can be cleared.
//
//   Optional feature macro: REG_DECODER_SEQ_ONEHOT_CHK_EN
//     defined   -> extra output 'err', a sticky flag that is set whenever the
//                  registered dec has more than one bit set.
//     undefined -> no err port and no check logic.
//
// Parameters
//   ADDR_W    address width
//   NUM_OUT   number of output lines, 2 <= NUM_OUT <= 2**ADDR_W
//   MASK_ZERO 1: line 0 is never asserted; 0: line 0 is an ordinary line
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   en         in   decode request
//   addr       in   line to select when en=1
//   sweep_req  in   start-sweep request
//   dec        out  registered one-hot (or all-zero) select
//   busy       out  1 while a sweep is running (SWEEP or DONE state)
//   done       out  1-cycle pulse after the last sweep line
//   oob        out  1-cycle pulse: en=1 with addr >= NUM_OUT
//   dropped    out  1-cycle pulse: en=1 while busy
//   err        out  (macro only) sticky multi-hot flag
module reg_decoder_seq #(
    parameter int ADDR_W    = 5,
    parameter int NUM_OUT   = 32,
    parameter int MASK_ZERO = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               sweep_req,
    output logic [NUM_OUT-1:0] dec,
    output logic               busy,
    output logic               done,
    output logic               oob,
    output logic               dropped
`ifdef REG_DECODER_SEQ_ONEHOT_CHK_EN
    ,
    output logic               err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // With MASK_ZERO the sweep skips line 0, which can never be written.
    localparam logic [ADDR_W-1:0] IDX_FIRST = (MASK_ZERO != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_OUT - 1);

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  idx_reg, idx_next;
    logic [NUM_OUT-1:0] dec_reg, dec_next;
    logic               done_reg, done_next;
    logic               oob_reg, oob_next;
    logic               dropped_reg, dropped_next;

    logic [NUM_OUT-1:0] addr_hot;
    logic [NUM_OUT-1:0] idx_hot;
    logic               addr_in_range;

    // Zero-extend by one bit so NUM_OUT = 2**ADDR_W compares without wrap.
    assign addr_in_range = ({1'b0, addr} < (ADDR_W + 1)'(NUM_OUT));

    // Per-line match terms. An out-of-range addr matches no line, so
    // addr_hot is already all-zero in that case.
    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_line
            if (MASK_ZERO != 0 && gi == 0) begin : g_masked
                assign addr_hot[gi] = 1'b0;
            end else begin : g_normal
                assign addr_hot[gi] = (addr == ADDR_W'(gi));
            end
            assign idx_hot[gi] = (idx_reg == ADDR_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        dec_next     = '0;
        done_next    = 1'b0;
        oob_next     = 1'b0;
        dropped_next = 1'b0;
        case (state_reg)
            IDLE: begin
                // A decode requested together with sweep_req is still
                // performed; its line shows while the FSM enters SWEEP.
                if (en) begin
                    dec_next = addr_hot;
                    oob_next = !addr_in_range;
                end
                if (sweep_req) begin
                    state_next = SWEEP;
                    idx_next   = IDX_FIRST;
                end
            end
            SWEEP: begin
                dec_next     = idx_hot;
                dropped_next = en;
                if (idx_reg == IDX_LAST) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + ADDR_W'(1);
                end
            end
            DONE: begin
                done_next    = 1'b1;
                dropped_next = en;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            dec_reg     <= '0;
            done_reg    <= 1'b0;
            oob_reg     <= 1'b0;
            dropped_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            dec_reg     <= dec_next;
            done_reg    <= done_next;
            oob_reg     <= oob_next;
            dropped_reg <= dropped_next;
        end
    end

    assign dec     = dec_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign oob     = oob_reg;
    assign dropped = dropped_reg;

`ifdef REG_DECODER_SEQ_ONEHOT_CHK_EN
    // dec has exactly NUM_OUT bits, so no line >= NUM_OUT can exist in it;
    // the only possible fault visible on the register is a multi-hot value.
    logic multi_hot;
    logic err_reg;

    assign multi_hot = |(dec_reg & (dec_reg - NUM_OUT'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (multi_hot) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_reg_decoder_seq.sv
module tb_reg_decoder_seq;

    typedef struct {
        int          cyc;
        logic [31:0] dec;
        logic        done;
        logic        oob;
        logic        dropped;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    // u0: defaults (ADDR_W=5, NUM_OUT=32, MASK_ZERO=1)
    logic        en0 = 1'b0;
    logic [4:0]  addr0 = '0;
    logic        swp0 = 1'b0;
    logic [31:0] dec0;
    logic        busy0, done0, oob0, dropped0;
    // u1: NUM_OUT=24, MASK_ZERO=0
    logic        en1 = 1'b0;
    logic [4:0]  addr1 = '0;
    logic        swp1 = 1'b0;
    logic [23:0] dec1;
    logic        busy1, done1, oob1, dropped1;
`ifdef REG_DECODER_SEQ_ONEHOT_CHK_EN
    logic        err0, err1;
`endif

    exp_t q0[$];
    exp_t q1[$];

    reg_decoder_seq u0 (
        .clk(clk), .reset(rst), .en(en0), .addr(addr0), .sweep_req(swp0),
        .dec(dec0), .busy(busy0), .done(done0), .oob(oob0), .dropped(dropped0)
`ifdef REG_DECODER_SEQ_ONEHOT_CHK_EN
        , .err(err0)
`endif
    );

    reg_decoder_seq #(.ADDR_W(5), .NUM_OUT(24), .MASK_ZERO(0)) u1 (
        .clk(clk), .reset(rst), .en(en1), .addr(addr1), .sweep_req(swp1),
        .dec(dec1), .busy(busy1), .done(done1), .oob(oob1), .dropped(dropped1)
`ifdef REG_DECODER_SEQ_ONEHOT_CHK_EN
        , .err(err1)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", nm, act, cyc);
        end
    endtask

    task automatic push0(input int c, input logic [31:0] d, input logic dn, input logic ob,
                         input logic dr, input logic bs);
        exp_t e;
        e.cyc = c; e.dec = d; e.done = dn; e.oob = ob; e.dropped = dr; e.busy = bs;
        q0.push_back(e);
    endtask

    task automatic push1(input int c, input logic [31:0] d, input logic dn, input logic ob,
                         input logic dr, input logic bs);
        exp_t e;
        e.cyc = c; e.dec = d; e.done = dn; e.oob = ob; e.dropped = dr; e.busy = bs;
        q1.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: whenever a DUT shows any output activity, pop and compare.
    always @(negedge clk) begin
        exp_t e;
        if (dec0 != 0 || done0 || oob0 || dropped0) begin
            if (q0.size() == 0) begin
                check("u0_unexpected", {dec0, done0, oob0, dropped0, busy0}, 36'h0);
            end else begin
                e = q0.pop_front();
                check("u0_cycle", 36'(cyc), 36'(e.cyc));
                check("u0_out", {dec0, done0, oob0, dropped0, busy0},
                      {e.dec, e.done, e.oob, e.dropped, e.busy});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (dec1 != 0 || done1 || oob1 || dropped1) begin
            if (q1.size() == 0) begin
                check("u1_unexpected", {8'h0, dec1, done1, oob1, dropped1, busy1}, 36'h0);
            end else begin
                e = q1.pop_front();
                check("u1_cycle", 36'(cyc), 36'(e.cyc));
                check("u1_out", {8'h0, dec1, done1, oob1, dropped1, busy1},
                      {e.dec, e.done, e.oob, e.dropped, e.busy});
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [4:0]  a1[5];
        logic [31:0] d1[5];
        logic        o1[5];
        int          base;

        // Reset state
        #2;
        check("reset_u0", {dec0, done0, oob0, dropped0, busy0}, 36'h0);
        check("reset_u1", {8'h0, dec1, done1, oob1, dropped1, busy1}, 36'h0);
        step(); step();
        rst = 1'b0;
        step();

        // Plain decodes on u0: addr 5, masked 0, top line 31, back-to-back 1,2
        en0 = 1'b1; addr0 = 5'd5;  push0(cyc + 1, 32'h0000_0020, 0, 0, 0, 0); step();
        en0 = 1'b0;                                                          step();
        en0 = 1'b1; addr0 = 5'd0;                                            step();
        en0 = 1'b1; addr0 = 5'd31; push0(cyc + 1, 32'h8000_0000, 0, 0, 0, 0); step();
        en0 = 1'b1; addr0 = 5'd1;  push0(cyc + 1, 32'h0000_0002, 0, 0, 0, 0); step();
        en0 = 1'b1; addr0 = 5'd2;  push0(cyc + 1, 32'h0000_0004, 0, 0, 0, 0); step();
        en0 = 1'b0; step(); step();

        // u1 (NUM_OUT=24, line 0 usable): in-range, boundary and out-of-range
        a1 = '{5'd0, 5'd23, 5'd24, 5'd30, 5'd7};
        d1 = '{32'h1, 32'h0080_0000, 32'h0, 32'h0, 32'h80};
        o1 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            en1 = 1'b1; addr1 = a1[i];
            push1(cyc + 1, d1[i], 0, o1[i], 0, 0);
            step();
        end
        en1 = 1'b0; step(); step();

        // u1 sweep: lines 0..23, then done
        swp1 = 1'b1;
        base = cyc;
        for (int j = 0; j <= 26; j++) begin
            if (j >= 1 && j <= 24) push1(base + j + 1, 32'h1 << (j - 1), 0, 0, 0, 1);
            if (j == 25) push1(base + j + 1, 32'h0, 1, 0, 0, 0);
            step();
            swp1 = 1'b0;
        end

        // u0 same-cycle decode + sweep, with a collision, a sweep_req while
        // busy, and a request landing in the DONE cycle
        base = cyc;
        for (int j = 0; j <= 33; j++) begin
            en0 = (j == 0 || j == 10 || j == 32);
            addr0 = (j == 32) ? 5'd4 : 5'd3;
            swp0 = (j == 0 || j == 5);
            d = (j == 0) ? 32'h8 : ((j >= 1 && j <= 31) ? (32'h1 << j) : 32'h0);
            if (d != 0 || j == 32 || j == 10)
                push0(base + j + 1, d, (j == 32), 0, (j == 10 || j == 32), (j <= 31));
            step();
        end
        en0 = 1'b0; swp0 = 1'b0;
        step(); step();

        // u0 sweep aborted by reset while idx=7
        swp0 = 1'b1;
        base = cyc;
        for (int j = 0; j <= 6; j++) begin
            if (j >= 1) push0(base + j + 1, 32'h1 << j, 0, 0, 0, 1);
            step();
            swp0 = 1'b0;
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_reset", {dec0, done0, oob0, dropped0, busy0}, 36'h0);
        step(); step();
        rst = 1'b0;
        for (int j = 0; j < 40; j++) step();

        // Every expected response must have been seen
        check("u0_pending", 36'(q0.size()), 36'h0);
        check("u1_pending", 36'(q1.size()), 36'h0);
`ifdef REG_DECODER_SEQ_ONEHOT_CHK_EN
        check("err_sticky", {34'h0, err0, err1}, 36'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
